// File: rtl/sorted_block_merger.sv
// Two-way merge of two sorted BLK-element signed blocks into one
// 2*BLK-element ascending run, streamed one element per cycle.
module sorted_block_merger #(
    parameter int N   = 7,
    parameter int BLK = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK*N-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_data,
    output logic                out_last
);

    localparam int AW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int PW = $clog2(BLK + 1);
    localparam int CW = $clog2(2 * BLK);
    localparam logic [PW-1:0] PEND  = PW'(BLK);
    localparam logic [CW-1:0] CLAST = CW'(2 * BLK - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, MERGE} state_e;

    state_e              state_q;
    logic signed [N-1:0] bufa_q [BLK];
    logic signed [N-1:0] bufb_q [BLK];
    logic [PW-1:0]       ia_q, ia_d;
    logic [PW-1:0]       ib_q, ib_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic signed [N-1:0] head_a, head_b;
    logic                take_a;

    // Ties resolve toward A so equal keys keep A-before-B order
    always_comb begin
        head_a = bufa_q[ia_q[AW-1:0]];
        head_b = bufb_q[ib_q[AW-1:0]];
        take_a = (ia_q != PEND) && ((ib_q == PEND) || (head_a <= head_b));
        ia_d   = ia_q + PW'(take_a);
        ib_d   = ib_q + PW'(!take_a);
        cnt_d  = cnt_q + 1'b1;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? (take_a ? head_a : head_b) : '0;
    assign out_last  = out_valid_q && (cnt_q == CLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            ia_q        <= '0;
            ib_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < BLK; i++) begin
                bufa_q[i] <= '0;
                bufb_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (in_valid) begin
                        for (int i = 0; i < BLK; i++)
                            bufa_q[i] <= in_data[i*N +: N];
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        for (int i = 0; i < BLK; i++)
                            bufb_q[i] <= in_data[i*N +: N];
                        ia_q        <= '0;
                        ib_q        <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= MERGE;
                    end
                end
                MERGE: begin
                    if (out_ready) begin
                        ia_q  <= ia_d;
                        ib_q  <= ib_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == CLAST) begin
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= LOAD_A;
                        end
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

endmodule

// File: doc/sorted_block_merger.md
# sorted_block_merger

Streaming merge stage downstream of the 8-input bitonic sorters. Accepts two ascending-sorted 8-element signed blocks (A, then B) over a valid/ready parallel interface and emits the 16-element ascending merge one element per cycle on a valid/ready serial interface. It consumes the sorter outputs and pairs two sorter results into a 16-long sorted run without a second sorting network.

## Interface
- N, default 7: element width, two's-complement signed.
- BLK, default 8: elements per input block; output run length is 2*BLK.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data holds a sorted block.
- in_ready  output  1  block accepted on a cycle with in_valid && in_ready.
- in_data  input  BLK*N  packed block, element 0 in bits [N-1:0], ascending toward MSB.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  element consumed on a cycle with out_valid && out_ready.
- out_data  output  N  current merged element, signed.
- out_last  output  1  high with the 2*BLK-th element of a run.

## Operation
- States: LOAD_A, LOAD_B, MERGE. Buffers bufA[0:BLK-1] and bufB[0:BLK-1], pointers ia and ib (0..BLK), output counter cnt (0..2*BLK-1).
- LOAD_A: in_ready=1, out_valid=0. On handshake: bufA <= in_data, go to LOAD_B.
- LOAD_B: in_ready=1, out_valid=0. On handshake: bufB <= in_data, ia=ib=cnt=0, go to MERGE.
- MERGE: in_ready=0, out_valid=1. Head select:
  - ia<BLK and ib<BLK: signed compare; bufA[ia] <= bufB[ib] selects A (ties go to A), else B.
  - ia==BLK: B. ib==BLK: A.
- out_data = selected head, from registered buffers and pointers only; stable while out_valid && !out_ready.
- On output handshake: selected pointer +1, cnt +1. out_last = (cnt==2*BLK-1). Handshake with out_last goes to LOAD_A.
- Input sortedness is not checked; an unsorted block still produces the deterministic merge result defined by the rules above.
- in_valid is ignored outside LOAD_A/LOAD_B. out_ready is ignored outside MERGE.

## Timing
- Reset (rst high at an edge): state=LOAD_A, buffers=0, ia=ib=cnt=0. After the edge: in_ready=1, out_valid=0, out_data=0, out_last=0. Handshakes are ignored in any cycle with rst high.
- Reset mid-merge discards both buffers and the partial run. No out_last is produced for the aborted run.
- Latency: B accepted at edge k; out_valid=1 in the cycle after edge k, showing the first element.
- Throughput with out_ready held high: 16 elements in 16 consecutive cycles. in_ready rises in the cycle after the out_last handshake. Minimum period per run: 2 load cycles + 16 output cycles.
- Back-to-back blocks: A and B can be accepted on consecutive edges.
- out_valid never drops in MERGE before the out_last handshake. Pointers never exceed BLK.

## Test plan
- Interleaved merge (N=7). A = -64,-3,0,1,5,9,20,63 and B = -10,-3,2,2,4,8,30,62, out_ready=1. Required: -64,-10,-3,-3,0,1,2,2,4,5,8,9,20,30,62,63 on 16 consecutive cycles. The first -3 comes from A. out_last only on 63. First out_valid is one cycle after the B handshake.
- Disjoint ranges. A = 0..7, B = -8..-1. Required: B drains fully first (-8..-1), then A (0..7). ia stays 0 for the first 8 outputs.
- All ties. A = B = all 5. Required: sixteen 5s. The first 8 outputs advance ia, the last 8 advance ib.
- Backpressure. Random out_ready at 30% duty on the interleaved case. Required: same sequence, out_data stable while stalled, in_ready=0 throughout MERGE, in_ready=1 the cycle after the out_last handshake.
- Reset mid-merge. rst=1 for one cycle after the 5th output handshake. Required after reset: out_valid=0, in_ready=1, out_data=0. A fresh A/B pair then merges correctly from element 0.
- Ignored inputs. Pulse in_valid during MERGE, and pulse out_ready during LOAD_A/LOAD_B. Required: no buffer or pointer change, and no spurious output.
